// File: rtl/count_monitor.sv
// count_monitor: watches a 4-bit up counter, keeps a saturating wrap tally and
// queues match/wrap/error events in a 2-entry valid/ready FIFO.
// Optional feature: define COUNT_MONITOR_SEQ_CHECK_EN for sequence-error detection.
module count_monitor #(
  parameter logic [3:0] CMP_INIT = 4'd15,
  parameter int         WRAP_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        count_in,
  input  logic [3:0]        cmp_in,
  input  logic              cmp_valid,
  output logic              cmp_ready,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [1:0]        evt_code,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              err_sticky,
  output logic              evt_ovf
);

  localparam logic [1:0] CODE_MATCH = 2'b00;
  localparam logic [1:0] CODE_WRAP  = 2'b01;
  localparam logic [1:0] CODE_ERR   = 2'b10;

  typedef enum logic {PRIME, TRACK} state_t;

  state_t     state, state_next;
  logic [3:0] prev;
  logic [3:0] cmp_reg;
  logic [1:0] fifo_mem [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] fifo_cnt;

  logic       is_stall, is_step, is_wrap, is_err, is_match;
  logic       push, drop, push_ok, pop, fifo_full;
  logic [1:0] push_code;

  assign cmp_ready = ~reset;
  assign evt_valid = (fifo_cnt != 2'd0);
  assign fifo_full = (fifo_cnt == 2'd2);
  assign pop       = evt_valid & evt_ready;
  assign push_ok   = push & (~fifo_full | pop);
  assign evt_code  = evt_valid ? fifo_mem[rd_ptr] : CODE_MATCH;

  // Classify the sample against prev; only the highest-priority event is pushed
  always_comb begin
    state_next = state;
    is_stall   = 1'b0;
    is_step    = 1'b0;
    is_wrap    = 1'b0;
    is_err     = 1'b0;
    is_match   = 1'b0;
    push       = 1'b0;
    push_code  = CODE_MATCH;
    drop       = 1'b0;
    case (state)
      PRIME: state_next = TRACK;
      TRACK: begin
        is_stall = (count_in == prev);
        is_wrap  = (prev == 4'd15) && (count_in == 4'd0);
        is_step  = (prev != 4'd15) && (count_in == prev + 4'd1);
`ifdef COUNT_MONITOR_SEQ_CHECK_EN
        is_err   = ~(is_stall | is_wrap | is_step);
`endif
        is_match = (is_step | is_wrap) && (count_in == cmp_reg);
        if (is_err) begin
          push      = 1'b1;
          push_code = CODE_ERR;
        end else if (is_wrap) begin
          push      = 1'b1;
          push_code = CODE_WRAP;
          drop      = is_match;
        end else if (is_match) begin
          push      = 1'b1;
          push_code = CODE_MATCH;
        end
      end
      default: state_next = PRIME;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= PRIME;
      prev        <= 4'd0;
      cmp_reg     <= CMP_INIT;
      wrap_count  <= '0;
      evt_ovf     <= 1'b0;
      fifo_mem[0] <= CODE_MATCH;
      fifo_mem[1] <= CODE_MATCH;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      state <= state_next;
      prev  <= count_in;
      if (cmp_valid && cmp_ready)
        cmp_reg <= cmp_in;
      if (is_wrap && (wrap_count != '1))
        wrap_count <= wrap_count + WRAP_W'(1);
      if (drop || (push && !push_ok))
        evt_ovf <= 1'b1;
      if (push_ok) begin
        fifo_mem[wr_ptr] <= push_code;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + 2'(push_ok) - 2'(pop);
    end
  end

`ifdef COUNT_MONITOR_SEQ_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_sticky <= 1'b0;
    else if (is_err)
      err_sticky <= 1'b1;
  end
`else
  assign err_sticky = 1'b0;
`endif

endmodule

// File: doc/count_monitor.md
# count_monitor

Downstream observer for the 4-bit synchronous up counter. It samples the counter's `q` bus every clock and tracks it against the previous sample. It produces three things: a saturating wrap tally, a programmable match event and a sequence-integrity check. Events are delivered through a 2-entry valid/ready queue, so a slower consumer (status/interrupt logic) can drain them.

## Interface
Parameters:
- `CMP_INIT`, 4'd15: compare register value after reset.
- `WRAP_W`, 8: width of the wrap tally.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `count_in` in 4: counter value, driven directly from the counter's `q`.
- `cmp_in` in 4: new compare value.
- `cmp_valid` in 1: `cmp_in` is valid.
- `cmp_ready` out 1: compare load accepted when `cmp_valid & cmp_ready`.
- `evt_valid` out 1: queue head holds an event.
- `evt_ready` in 1: consumer accepts the head event.
- `evt_code` out 2: head event code. 2'b00 = match, 2'b01 = wrap, 2'b10 = sequence error.
- `wrap_count` out `WRAP_W`: number of 15→0 wraps, saturating.
- `err_sticky` out 1: a sequence error has occurred since reset.
- `evt_ovf` out 1: sticky flag; at least one event was dropped.

## Operation
- Reset values:
  - state = PRIME, `prev` = 0, `cmp_reg` = `CMP_INIT`.
  - `wrap_count` = 0, queue empty.
  - `evt_valid` = 0, `evt_code` = 2'b00.
  - `err_sticky` = 0, `evt_ovf` = 0.
  - `cmp_ready` = 0 while `reset` is high.
- The FSM has two states, PRIME and TRACK.
  - PRIME: on the first edge after reset release, capture `count_in` into `prev`, go to TRACK, and raise no events.
  - TRACK: every edge, classify `count_in` against `prev`, then set `prev` = `count_in`.
- Classification in TRACK:
  - `count_in == prev`: stall; no event.
  - `count_in == prev+1` (mod 16), `prev != 15`: step.
  - `prev == 15` and `count_in == 0`: wrap. Increment `wrap_count`, holding at all-ones once saturated.
  - Any other value: sequence error. Set `err_sticky`.
- Match: a step or wrap whose new `count_in` equals `cmp_reg`. A stall never produces a match.
- Per-cycle event selection: at most one event is pushed per cycle, priority error > wrap > match.
  - A lower-priority event coincident with a higher one is dropped and sets `evt_ovf`. For example, a wrap with `cmp_reg` = 0 pushes wrap and sets `evt_ovf`.
- Queue behaviour:
  - 2-entry FIFO; the head drives `evt_code`.
  - Push when full and no pop in that cycle: the new event is dropped and `evt_ovf` is set.
  - Push and pop in the same cycle are both performed, including when the queue is full; nothing is dropped.
  - `evt_valid` = queue not empty.
- Compare load:
  - `cmp_ready` = 1 whenever not in reset.
  - On accept, `cmp_reg` ← `cmp_in` at that edge.
  - Classification in the same cycle still uses the old `cmp_reg`.
- Reset mid-operation: all state clears immediately, including queued events; the FSM returns to PRIME.

## Timing
- Event latency: `count_in` sampled at edge k produces `evt_valid`/`evt_code` visible after edge k if the queue was empty. That is one cycle from the value appearing on `count_in`.
- Queue order is FIFO: the first event remains at the head until `evt_valid & evt_ready` at an edge.
- `wrap_count` and `err_sticky` update at the same edge as classification.
- `evt_ovf` updates at the edge of the drop.
- No combinational path from `count_in` or `evt_ready` to any output. All outputs are registered, or decoded from registered queue pointers.

## Configuration
- `COUNT_MONITOR_SEQ_CHECK_EN` defined:
  - Sequence-error classification, error events (code 2'b10) and `err_sticky` are compiled in, as described above.
- Not defined:
  - Non-step, non-wrap, non-stall transitions are treated as a plain update of `prev`, with no event and no match.
  - `err_sticky` is tied to 0.
  - Code 2'b10 is never produced.

## Test plan
- Reset, then free-running counter, `CMP_INIT` = 15, `evt_ready` = 1:
  - first event is match when `count_in` = 15, then wrap at 0 on the next cycle.
  - `wrap_count` = 3 after 3 full cycles.
- `evt_ready` = 0 through 3 matches (`cmp_reg` = 5, 48 counts):
  - queue holds match, match; `evt_ovf` = 1.
  - Raising `evt_ready` drains exactly 2 events.
- Load `cmp_in` = 0 with `cmp_valid`, then run through a wrap:
  - single wrap event pushed, `evt_ovf` = 1.
- With the macro defined, force `count_in` 3→7:
  - error event 2'b10, `err_sticky` = 1, no match even if `cmp_reg` = 7.
- Run with `wrap_count` preloaded via 255 wraps, then one more wrap:
  - `wrap_count` stays 255.
- Assert `reset` while the queue holds 2 events:
  - `evt_valid` = 0 immediately, `wrap_count` = 0.
  - The first post-reset sample is only captured (PRIME), and no event is raised.
